// File: rtl/sico_sched_pkg.sv
// Shared sizing helpers for the SiCo playback scheduler and its event FIFO.
package sico_sched_pkg;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Flat event word layout, MSB first: {time, sync, value}.
   function automatic int unsigned ev_w(input int unsigned width, input int unsigned time_w);
      return time_w + 1 + width;
   endfunction

endpackage

// File: rtl/sico_sched_fifo.sv
// Synchronous event FIFO. The head word comes straight from the storage flops,
// so a word written on one edge is readable in the very next cycle.
module sico_sched_fifo
   import sico_sched_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LW    = level_w(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] din_i,
   input  logic          pop_i,
   output logic [DW-1:0] dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == LW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign level_o = cnt_q;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      cnt_d    = cnt_q + LW'(do_push) - LW'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: only words behind a valid count are ever read.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/sico_play_scheduler.sv
// Playback scheduler: buffers timestamped events and applies each to val_o at
// its deadline (sync) or on the next fixed-rate divider tick (async).
module sico_play_scheduler
   import sico_sched_pkg::*;
#(
   parameter int unsigned       WIDTH     = 8,
   parameter int unsigned       DEPTH     = 4,
   parameter int unsigned       TIME_W    = 32,
   parameter logic [WIDTH-1:0]  RST_VAL   = '0,
   parameter int unsigned       ASYNC_DIV = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        ev_valid_i,
   output logic                        ev_ready_o,
   input  logic [TIME_W-1:0]           ev_time_i,
   input  logic                        ev_sync_i,
   input  logic [WIDTH-1:0]            ev_value_i,
   output logic [WIDTH-1:0]            val_o,
   output logic                        fire_o,
   output logic                        late_o,
   output logic [TIME_W-1:0]           now_o,
   output logic [level_w(DEPTH)-1:0]   level_o
);
   localparam int unsigned EW    = ev_w(WIDTH, TIME_W);
   localparam int unsigned LW    = level_w(DEPTH);
   localparam int unsigned DIV_W = (ASYNC_DIV > 1) ? $clog2(ASYNC_DIV) : 1;

   logic [TIME_W-1:0] now_q, now_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [WIDTH-1:0]  val_q, val_d;
   logic              fire_q, fire_d;
   logic              late_q, late_d;

   logic [EW-1:0]     head;
   logic [TIME_W-1:0] head_time;
   logic              head_sync;
   logic [WIDTH-1:0]  head_value;
   logic              full, empty, push, tick, eligible;

   assign ev_ready_o = !full;
   assign push       = ev_valid_i && !full;
   assign head_time  = head[EW-1 -: TIME_W];
   assign head_sync  = head[WIDTH];
   assign head_value = head[WIDTH-1:0];
   assign tick       = (div_q == DIV_W'(ASYNC_DIV - 1));

   sico_sched_fifo #(
      .DW    (EW),
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .din_i   ({ev_time_i, ev_sync_i, ev_value_i}),
      .pop_i   (eligible),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level_o)
   );

   // Head-only eligibility keeps strict FIFO order: a waiting head blocks all.
   always_comb begin
      eligible = 1'b0;
      now_d    = now_q + TIME_W'(1);
      div_d    = tick ? '0 : div_q + DIV_W'(1);
      val_d    = val_q;
      late_d   = late_q;
      if (!empty) begin
         eligible = head_sync ? (now_q >= head_time) : tick;
      end
      fire_d = eligible;
      if (eligible) begin
         val_d = head_value;
         if (head_sync && (now_q > head_time)) begin
            late_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         now_q  <= '0;
         div_q  <= '0;
         val_q  <= RST_VAL;
         fire_q <= 1'b0;
         late_q <= 1'b0;
      end else begin
         now_q  <= now_d;
         div_q  <= div_d;
         val_q  <= val_d;
         fire_q <= fire_d;
         late_q <= late_d;
      end
   end

   assign val_o  = val_q;
   assign fire_o = fire_q;
   assign late_o = late_q;
   assign now_o  = now_q;

endmodule

// File: tb/tb_sico_play_scheduler.sv
// Bench for sico_play_scheduler: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the playback rules.
module tb_sico_play_scheduler;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned ASYNC_DIV = 16;

   typedef struct {
      logic [31:0] t;
      logic        s;
      logic [7:0]  v;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic [31:0] ev_time = '0;
   logic        ev_sync = 1'b0;
   logic [7:0]  ev_value = '0;
   logic [7:0]  val;
   logic        fire, late;
   logic [31:0] now;
   logic [2:0]  level;

   int n_tests = 0;
   int n_fail  = 0;

   ev_t         q[$];
   int unsigned m_now  = 0;
   logic [7:0]  m_val  = 8'h00;
   logic        m_fire = 1'b0;
   logic        m_late = 1'b0;
   logic        accepted = 1'b0;

   sico_play_scheduler #(
      .WIDTH     (8),
      .DEPTH     (DEPTH),
      .TIME_W    (32),
      .RST_VAL   (8'h00),
      .ASYNC_DIV (ASYNC_DIV)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .ev_valid_i (ev_valid),
      .ev_ready_o (ev_ready),
      .ev_time_i  (ev_time),
      .ev_sync_i  (ev_sync),
      .ev_value_i (ev_value),
      .val_o      (val),
      .fire_o     (fire),
      .late_o     (late),
      .now_o      (now),
      .level_o    (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @now=%0d: got %0h expected %0h", tag, m_now, got, exp);
      end
   endtask

   // Compare current outputs, advance the model by one cycle, then step the clock.
   task automatic cycle();
      logic elig;
      ev_t  h;
      check("now",   64'(now),      64'(m_now));
      check("val",   64'(val),      64'(m_val));
      check("fire",  64'(fire),     64'(m_fire));
      check("late",  64'(late),     64'(m_late));
      check("level", 64'(level),    64'(q.size()));
      check("ready", 64'(ev_ready), 64'(q.size() < DEPTH));
      if (rst) begin
         q.delete();
         m_now = 0; m_val = 8'h00; m_fire = 1'b0; m_late = 1'b0;
         accepted = 1'b0;
      end else begin
         accepted = ev_valid && (q.size() < DEPTH);
         elig = 1'b0;
         if (q.size() > 0) begin
            h = q[0];
            elig = h.s ? (m_now >= h.t) : ((m_now % ASYNC_DIV) == ASYNC_DIV - 1);
         end
         m_fire = elig;
         if (elig) begin
            m_val = h.v;
            if (h.s && m_now > h.t) m_late = 1'b1;
            void'(q.pop_front());
         end
         if (accepted) q.push_back('{t: ev_time, s: ev_sync, v: ev_value});
         m_now++;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic offer(input logic [31:0] t, input logic s, input logic [7:0] v);
      ev_valid = 1'b1; ev_time = t; ev_sync = s; ev_value = v;
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (accepted) break;
      end
      check("offer_accepted", 64'(accepted), 64'(1));
      ev_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk); #1;
      do_reset();

      // Single sync event: deadline 10, pushed at now=2.
      idle(2);
      offer(32'd10, 1'b1, 8'hA5);
      idle(12);

      // Fill FIFO with same-deadline events; fifth offer stalls until a pop.
      do_reset();
      offer(32'd20, 1'b1, 8'h01);
      offer(32'd20, 1'b1, 8'h02);
      offer(32'd20, 1'b1, 8'h03);
      offer(32'd21, 1'b1, 8'h04);
      offer(32'd40, 1'b1, 8'h05);
      idle(25);

      // Async event pushed at now=3 lands on the tick at now=15.
      do_reset();
      idle(3);
      offer(32'd0, 1'b0, 8'h3C);
      idle(16);

      // Far-future head blocks an already-due event behind it.
      do_reset();
      offer(32'd100, 1'b1, 8'h11);
      offer(32'd5, 1'b1, 8'h22);
      idle(105);

      // Reset with events pending discards them.
      do_reset();
      offer(32'd500, 1'b1, 8'h31);
      offer(32'd501, 1'b1, 8'h32);
      offer(32'd502, 1'b1, 8'h33);
      idle(2);
      do_reset();
      idle(3);

      // Random traffic; producer holds each offer until accepted.
      for (int i = 0; i < 1500; i++) begin
         if (!ev_valid && $urandom_range(0, 2) == 0) begin
            ev_valid = 1'b1;
            ev_sync  = ($urandom_range(0, 3) != 0);
            ev_time  = (m_now > 5 && $urandom_range(0, 4) == 0) ? m_now - 5
                                                               : m_now + $urandom_range(0, 20);
            ev_value = 8'($urandom);
         end
         rst = ($urandom_range(0, 199) == 0);
         cycle();
         if (accepted) ev_valid = 1'b0;
      end
      rst = 1'b0;
      ev_valid = 1'b0;
      idle(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
